// File: rtl/vta_ctrl_regs.sv
// AXI4-Lite control/status register file for a VTA compute engine (CTRL, CYCLES, LEN, NUM_PTR pointers).
// Optional macro VTA_CTRL_IRQ_EN adds the irq output, CTRL.ie (bit2) and write-one-to-clear of done (bit1).
module vta_ctrl_regs #(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PTR        = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic                      launch,
    input  logic                      finish,
    output logic [DATA_WIDTH-1:0]     len,
`ifdef VTA_CTRL_IRQ_EN
    output logic                      irq,
`endif
    output logic [NUM_PTR*32-1:0]     ptr
);

    localparam int unsigned NUM_REGS    = 32'd3 + 32'(NUM_PTR);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_BUSY = 2'd1, C_DONE = 2'd2} c_state_t;

    w_state_t w_state_r, w_next_s;
    r_state_t r_state_r, r_next_s;
    c_state_t c_state_r, c_next_s;

    logic                  awready_r, bvalid_r, arready_r, rvalid_r, launch_r;
    logic [1:0]            bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r, len_r, cycles_r, rd_data_s, rd_ptr_s, ctrl_rd_s;
    logic [DATA_WIDTH-1:0] ptr_r [NUM_PTR];
    logic [31:0]           w_idx_s, r_idx_s;
    logic                  w_map_s, r_map_s, wr_en_s, wr_ctrl_s, start_s, clr_s, launch_s;
    logic                  busy_s, done_s, ie_s;
    logic                  unused_addr_s;

    function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                         input logic [DATA_WIDTH-1:0] new_v,
                                                         input logic [DATA_WIDTH/8-1:0] strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
            else         res[8*b +: 8] = old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_addr_s = ^{s_awaddr[1:0], s_araddr[1:0]};
    assign w_idx_s   = 32'(s_awaddr[AXI_ADDR_WIDTH-1:2]);
    assign r_idx_s   = 32'(s_araddr[AXI_ADDR_WIDTH-1:2]);
    assign w_map_s   = (w_idx_s < NUM_REGS);
    assign r_map_s   = (r_idx_s < NUM_REGS);
    assign wr_en_s   = (w_state_r == W_ACK);
    assign wr_ctrl_s = wr_en_s && (w_idx_s == 32'd0);
    assign start_s   = wr_ctrl_s && s_wdata[0] && s_wstrb[0];
    assign busy_s    = (c_state_r == C_BUSY);
    assign done_s    = (c_state_r == C_DONE);
    assign ctrl_rd_s = {{(DATA_WIDTH-3){1'b0}}, ie_s, done_s, busy_s};

    // Write channel next-state: accept AW+W together, then hold the response until bready.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (s_awvalid && s_wvalid) w_next_s = W_ACK; else w_next_s = W_IDLE;
            W_ACK:   w_next_s = W_RESP;
            W_RESP:  if (s_bready) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write channel state and registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_ACK);
            bvalid_r  <= (w_next_s == W_RESP);
            if (wr_en_s) bresp_r <= w_map_s ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read channel next-state: single-beat address accept, then hold data until rready.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (s_arvalid) r_next_s = R_ACK; else r_next_s = R_IDLE;
            R_ACK:   r_next_s = R_DATA;
            R_DATA:  if (s_rready) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read data mux; unmapped offsets fall through to zero.
    always_comb begin
        rd_ptr_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_PTR; i++) begin
            rd_ptr_s = rd_ptr_s | ((r_idx_s == 32'd3 + 32'(i)) ? ptr_r[i] : {DATA_WIDTH{1'b0}});
        end
        if (r_idx_s == 32'd0)      rd_data_s = ctrl_rd_s;
        else if (r_idx_s == 32'd1) rd_data_s = cycles_r;
        else if (r_idx_s == 32'd2) rd_data_s = len_r;
        else                       rd_data_s = rd_ptr_s;
    end

    // Read channel state; data and response are captured on the address handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_ACK);
            rvalid_r  <= (r_next_s == R_DATA);
            if (r_state_r == R_ACK) begin
                rdata_r <= rd_data_s;
                rresp_r <= r_map_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Control FSM: finish has priority over a start landing in the same BUSY cycle.
    always_comb begin
        c_next_s = c_state_r;
        launch_s = 1'b0;
        case (c_state_r)
            C_IDLE: begin
                if (start_s) begin c_next_s = C_BUSY; launch_s = 1'b1; end
                else         c_next_s = C_IDLE;
            end
            C_BUSY:  if (finish) c_next_s = C_DONE; else c_next_s = C_BUSY;
            C_DONE: begin
                if (start_s)    begin c_next_s = C_BUSY; launch_s = 1'b1; end
                else if (clr_s) c_next_s = C_IDLE;
                else            c_next_s = C_DONE;
            end
            default: c_next_s = C_IDLE;
        endcase
    end

    // Control state, launch pulse, saturating busy-cycle counter and LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state_r <= C_IDLE;
            launch_r  <= 1'b0;
            cycles_r  <= {DATA_WIDTH{1'b0}};
            len_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            c_state_r <= c_next_s;
            launch_r  <= launch_s;
            if (launch_s)
                cycles_r <= {DATA_WIDTH{1'b0}};
            else if (busy_s) begin
                if (!finish && (cycles_r != {DATA_WIDTH{1'b1}})) cycles_r <= cycles_r + 32'd1;
            end else if (wr_en_s && (w_idx_s == 32'd1))
                cycles_r <= s_wdata;
            if (wr_en_s && (w_idx_s == 32'd2)) len_r <= apply_strb(len_r, s_wdata, s_wstrb);
        end
    end

    for (genvar i = 0; i < NUM_PTR; i++) begin : g_ptr
        localparam int unsigned PTR_IDX = 32'd3 + 32'(i);
        // Pointer register i with byte strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                             ptr_r[i] <= {DATA_WIDTH{1'b0}};
            else if (wr_en_s && w_idx_s == PTR_IDX) ptr_r[i] <= apply_strb(ptr_r[i], s_wdata, s_wstrb);
        end
        assign ptr[32*i +: 32] = ptr_r[i];
    end

`ifdef VTA_CTRL_IRQ_EN
    logic ie_r, irq_r;
    assign clr_s = wr_ctrl_s && s_wdata[1];
    assign ie_s  = ie_r;
    assign irq   = irq_r;
    // Interrupt enable and level interrupt, one cycle behind done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (wr_ctrl_s && s_wstrb[0]) ie_r <= s_wdata[2];
            irq_r <= done_s && ie_r;
        end
    end
`else
    assign clr_s = 1'b0;
    assign ie_s  = 1'b0;
`endif

    assign s_awready = awready_r;
    assign s_wready  = awready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_arready = arready_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign launch    = launch_r;
    assign len       = len_r;

endmodule

// File: doc/vta_ctrl_regs.md
Name: vta_ctrl_regs

Overview:
- Parametrised AXI4-Lite slave control/status register file for a VTA compute engine.
- Generalises the fixed ctrl/len/3-pointer register layout: NUM_PTR pointer registers, a busy-cycle counter, SLVERR on unmapped accesses and byte strobes.
- Sits between the PS7 GP master and the engine. Drives launch, length and pointers; receives a finish pulse.

Parameters:
- AXI_ADDR_WIDTH, 8, AXI-Lite offset width (byte address).
- DATA_WIDTH, 32, register and AXI data width; only 32 is supported.
- NUM_PTR, 3, number of host pointer registers; legal range 1..61.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  32  write data.
- s_wstrb  in  4  write byte strobes.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  AXI_ADDR_WIDTH  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- launch  out  1  one-cycle start pulse to the engine.
- finish  in  1  one-cycle completion pulse from the engine.
- len  out  32  transfer length register.
- ptr  out  NUM_PTR*32  pointer registers; ptr i occupies bits [32i+31:32i].

Behaviour:
- Reset: every output and register is 0; both AXI FSMs idle; control FSM IDLE.
- Address map: word-aligned, addr[1:0] ignored.
  - 0x00 CTRL: bit0 start (write) / busy (read); bit1 done (read-only).
  - 0x04 CYCLES.
  - 0x08 LEN.
  - 0x0C+4i PTR i, for i < NUM_PTR.
  - Any other offset is unmapped.
- Write channel (FSM W_IDLE, W_ACK, W_RESP):
  - W_IDLE: when awvalid and wvalid are both high, register awready=wready=1 for exactly one cycle (W_ACK).
  - W_ACK: perform the write on that handshake cycle. LEN and PTR honour wstrb per byte.
  - W_RESP: next cycle bvalid=1, held with a stable bresp until bready.
  - bresp = 2'b00 if mapped, 2'b10 if unmapped. An unmapped write has no side effect.
  - No new AW/W is accepted while bvalid=1.
- Read channel (FSM R_IDLE, R_ACK, R_DATA):
  - arvalid in R_IDLE -> arready=1 for one cycle.
  - Next cycle: rvalid=1 with rdata/rresp captured at the handshake, held stable until rready.
  - Unmapped read: rdata=0, rresp=2'b10.
  - Read and write channels are independent and may complete in the same cycle.
- Control FSM (IDLE, BUSY, DONE):
  - IDLE or DONE, CTRL write with wdata[0]=1 and wstrb[0]=1: launch=1 for the cycle after the write handshake; CYCLES cleared to 0; done cleared; go to BUSY.
  - BUSY: CYCLES increments every cycle and saturates at 0xFFFF_FFFF. A start write is ignored (response OKAY).
  - BUSY and finish=1: go to DONE, done=1, CYCLES frozen. If a start write lands in the same cycle, finish wins and start is dropped.
  - finish in IDLE or DONE is ignored.
- CYCLES writes load wdata when not BUSY and are ignored while BUSY.
- LEN and PTR are writable in any state; the engine latches them on launch.
- Reset mid-operation: immediate return to the reset state. Any in-flight AXI transaction is dropped. launch is never asserted from reset.

Optional Feature:
- Macro: VTA_CTRL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - CTRL bit2 = irq enable (RW, reset 0).
  - irq = done & ie, registered (one cycle after done rises).
  - Writing CTRL with wdata[1]=1 clears done (W1C) without launching; state goes DONE->IDLE.
- Undefined:
  - No irq port.
  - CTRL bit2 reads 0 and ignores writes.
  - done clears only on the next launch.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C -> rdata=0, rresp=00 for each; launch=0.
- Write LEN=5, PTR0=0xFFFC0000, PTR1=0xFFFD0000, PTR2=0xFFFF0000 -> bresp=00; len=5 and ptr bits match; read-back is identical.
- Write CTRL=1; engine asserts finish 40 cycles after launch -> launch pulses once; CTRL reads 1 while busy; afterwards CTRL=2 and CYCLES=40 (±1 by documented edge); a second start clears done and relaunches.
- Write CTRL=1 while BUSY, with finish coincident with a start write -> no second launch; state DONE.
- Write and read offset 0x0C+4*NUM_PTR (0x18 at default) -> bresp=10, rresp=10, rdata=0; no register changes.
- Hold bready/rready low 10 cycles -> bvalid/rvalid and bresp/rdata stay stable; wstrb=4'b0010 write of 0xAABBCCDD to LEN=0 -> LEN=0x0000CC00.
